// File: rtl/muldiv_if.sv
// Request/result bundle between the register-file read ports, the multiply/divide
// unit and the register-file write port.
interface muldiv_if #(
   parameter int W = 32,
   parameter int N = 5
);
   logic         start;
   logic [2:0]   funct3;
   logic [N-1:0] rd_in;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic         we;
   logic [N-1:0] rd;
   logic [W-1:0] data_out;

   modport master (
      output start, funct3, rd_in, op_a, op_b,
      input  busy, done, we, rd, data_out
   );

   modport slave (
      input  start, funct3, rd_in, op_a, op_b,
      output busy, done, we, rd, data_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed overflow and zero-operand multiply bypass CALC.
module muldiv_unit #(
   parameter int W = 32,
   parameter int N = 5
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(W);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_funct3;
   logic [N-1:0]  r_rd;
   logic [W-1:0]  r_data;
   logic [W-1:0]  r_hi;
   logic [W-1:0]  r_lo;
   logic [W-1:0]  r_b_mag;
   logic          r_neg;
   logic          r_force;
   logic [W-1:0]  r_force_val;

   logic          w_accept;
   logic          w_final;
   logic          w_is_div;
   logic          w_a_signed;
   logic          w_b_signed;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [W-1:0]  w_a_mag;
   logic [W-1:0]  w_b_mag;
   logic          w_div0;
   logic          w_ovf;
   logic          w_force;
   logic [W-1:0]  w_force_val;
   logic          w_early;
   logic [W:0]    w_mul_sum;
   logic [W:0]    w_div_shift;
   logic          w_div_ge;
   logic [W-1:0]  w_div_diff;
   logic [W-1:0]  w_hi_next;
   logic [W-1:0]  w_lo_next;
   logic [2*W-1:0] w_prod;
   logic [2*W-1:0] w_prod_s;
   logic [W-1:0]  w_div_val;
   logic [W-1:0]  w_div_s;
   logic [W-1:0]  w_result;

   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_final  = (r_state == CALC) && (r_cnt == CW'(W - 1));

   // Operand signedness: MULH/DIV/REM signed x signed, MULHSU signed x unsigned.
   assign w_is_div   = bus.funct3[2];
   assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0]
                                     : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
   assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
   assign w_a_neg    = w_a_signed & bus.op_a[W-1];
   assign w_b_neg    = w_b_signed & bus.op_b[W-1];
   assign w_a_mag    = w_a_neg ? -bus.op_a : bus.op_a;
   assign w_b_mag    = w_b_neg ? -bus.op_b : bus.op_b;

   assign w_div0  = w_is_div && (bus.op_b == '0);
   assign w_ovf   = w_is_div && !bus.funct3[0] && (bus.op_a == MIN_NEG) && (&bus.op_b);
   assign w_force = w_div0 | w_ovf;

   always_comb begin
      w_force_val = '0;
      if (w_div0)
         w_force_val = bus.funct3[1] ? bus.op_a : '1;
      else if (w_ovf)
         w_force_val = bus.funct3[1] ? '0 : MIN_NEG;
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign w_early = w_force | (!w_is_div && (bus.op_a == '0 || bus.op_b == '0));
`else
   assign w_early = 1'b0;
`endif

   // One iteration: multiply shifts {hi,lo} right after adding, divide shifts left.
   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b_mag} : '0);
   assign w_div_shift = {r_hi, r_lo[W-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
   assign w_div_diff  = w_div_shift[W-1:0] - r_b_mag;

   always_comb begin
      w_hi_next = w_mul_sum[W:1];
      w_lo_next = {w_mul_sum[0], r_lo[W-1:1]};
      if (r_funct3[2]) begin
         w_hi_next = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
         w_lo_next = {r_lo[W-2:0], w_div_ge};
      end
   end

   assign w_prod    = {w_hi_next, w_lo_next};
   assign w_prod_s  = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_div_val = r_funct3[1] ? w_hi_next : w_lo_next;
   assign w_div_s   = r_neg ? -w_div_val : w_div_val;

   always_comb begin
      w_result = (r_funct3[1:0] == 2'b00) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
      if (r_funct3[2])
         w_result = w_div_s;
      if (r_force)
         w_result = r_force_val;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = w_early ? DONE : CALC;
         CALC: if (w_final)  w_state_next = DONE;
         DONE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_funct3    <= '0;
         r_rd        <= '0;
         r_data      <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_b_mag     <= '0;
         r_neg       <= 1'b0;
         r_force     <= 1'b0;
         r_force_val <= '0;
      end else if (w_accept) begin
         r_cnt       <= '0;
         r_funct3    <= bus.funct3;
         r_rd        <= bus.rd_in;
         r_hi        <= '0;
         r_lo        <= w_a_mag;
         r_b_mag     <= w_b_mag;
         // Remainder follows the dividend's sign; everything else the sign product.
         r_neg       <= (bus.funct3[2] & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
         r_force     <= w_force;
         r_force_val <= w_force_val;
         if (w_early)
            r_data <= w_force_val;
      end else if (r_state == CALC) begin
         r_cnt <= r_cnt + CW'(1);
         r_hi  <= w_hi_next;
         r_lo  <= w_lo_next;
         if (w_final)
            r_data <= w_result;
      end
   end

   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == DONE);
   assign bus.we       = (r_state == DONE) && (r_rd != '0);
   assign bus.rd       = r_rd;
   assign bus.data_out = r_data;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_EARLY_OUT_EN for special-case latency.
module tb_muldiv_unit;
   localparam int W = 32;
   localparam int N = 5;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int EARLY = 1;
`else
   localparam int EARLY = 0;
`endif
   localparam int LAT_NORM = W;
   localparam int LAT_SPEC = (EARLY != 0) ? 0 : W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   muldiv_if #(.W(W), .N(N)) bus ();
   muldiv_unit #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Issues one request once idle; lat = edges from accept until done is seen (-1 on timeout).
   task automatic do_op(input logic [2:0] f, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] d,
                        output logic [4:0] ro, output logic weo, output logic busy_acc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      bus.start = 1'b1; bus.funct3 = f; bus.rd_in = r; bus.op_a = a; bus.op_b = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      busy_acc = bus.busy;
      lat = -1; d = '0; ro = '0; weo = 1'b0;
      for (int i = 0; i <= 100; i++) begin
         if (bus.done) begin
            lat = i; d = bus.data_out; ro = bus.rd; weo = bus.we;
            break;
         end
         @(posedge clk);
         #1;
      end
      $display("op f=%0d rd=%0d a=%h b=%h -> data=%h rd=%0d we=%0d lat=%0d",
               f, r, a, b, d, ro, weo, lat);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.funct3 = '0; bus.rd_in = '0; bus.op_a = '0; bus.op_b = '0;
      rst = 1'b0;
      #12;
      checks++;
      if ({bus.busy, bus.done, bus.we} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/done/we=%b required 000", {bus.busy, bus.done, bus.we});
      end
      checks++;
      if ({bus.rd, bus.data_out} !== 37'd0) begin
         errors++;
         $display("FAIL reset_data: rd=%0d data=%h required 0", bus.rd, bus.data_out);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_mul();
      int lat; logic [31:0] d; logic [4:0] ro; logic weo, ba;
      do_op(3'b000, 5'd5, 32'd7, 32'hFFFF_FFFD, lat, d, ro, weo, ba);
      checks++;
      if (ba !== 1'b1) begin errors++; $display("FAIL mul_busy: busy=%b required 1", ba); end
      checks++;
      if (lat !== LAT_NORM) begin errors++; $display("FAIL mul_lat: lat=%0d required %0d", lat, LAT_NORM); end
      checks++;
      if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: data=%h required ffffffeb", d); end
      checks++;
      if (weo !== 1'b1 || ro !== 5'd5) begin errors++; $display("FAIL mul_wb: we=%b rd=%0d required 1/5", weo, ro); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mul_done_pulse: done=%b busy=%b required 0/0", bus.done, bus.busy);
      end
      checks++;
      if (bus.data_out !== 32'hFFFF_FFEB || bus.rd !== 5'd5) begin
         errors++;
         $display("FAIL mul_hold: data=%h rd=%0d required ffffffeb/5", bus.data_out, bus.rd);
      end
   endtask

   task automatic run_table(input string name, input logic [2:0] fv [8], input logic [31:0] av [8],
                            input logic [31:0] bv [8], input logic [31:0] ev [8], input int lv [8]);
      int lat; logic [31:0] d; logic [4:0] ro; logic weo, ba;
      for (int i = 0; i < 8; i++) begin
         do_op(fv[i], 5'd3, av[i], bv[i], lat, d, ro, weo, ba);
         checks++;
         if (d !== ev[i]) begin
            errors++;
            $display("FAIL %s_data[%0d]: data=%h required %h", name, i, d, ev[i]);
         end
         checks++;
         if (lat !== lv[i] || weo !== 1'b1) begin
            errors++;
            $display("FAIL %s_timing[%0d]: lat=%0d we=%b required %0d/1", name, i, lat, weo, lv[i]);
         end
      end
   endtask

   task automatic test_mul_high();
      logic [2:0]  fv [8] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b001, 3'b011, 3'b010, 3'b011};
      logic [31:0] av [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003, 32'h0001_0000};
      logic [31:0] bv [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0010,
                              32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0001_0000};
      logic [31:0] ev [8] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2345_6780,
                              32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002, 32'h0000_0001};
      int          lv [8] = '{W, W, W, W, W, W, W, W};
      run_table("mulh", fv, av, bv, ev, lv);
   endtask

   task automatic test_div_rem();
      logic [2:0]  fv [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110};
      logic [31:0] av [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] bv [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFE};
      logic [31:0] ev [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFF2, 32'd2, 32'h7FFF_FFFC, 32'hFFFF_FFFF};
      int          lv [8] = '{W, W, W, W, W, W, W, W};
      run_table("div", fv, av, bv, ev, lv);
   endtask

   task automatic test_special();
      logic [2:0]  fv [8] = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b100, 3'b110, 3'b000, 3'b011};
      logic [31:0] av [8] = '{32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9,
                              32'h8000_0000, 32'h8000_0000, 32'd0, 32'h1234_5678};
      logic [31:0] bv [8] = '{32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'd0};
      logic [31:0] ev [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd9,
                              32'h8000_0000, 32'd0, 32'd0, 32'd0};
      int          lv [8] = '{LAT_SPEC, LAT_SPEC, LAT_SPEC, LAT_SPEC,
                              LAT_SPEC, LAT_SPEC, LAT_SPEC, LAT_SPEC};
      run_table("special", fv, av, bv, ev, lv);
   endtask

   task automatic test_rd_zero();
      int lat; logic [31:0] d; logic [4:0] ro; logic weo, ba;
      do_op(3'b011, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, d, ro, weo, ba);
      checks++;
      if (lat !== LAT_NORM) begin errors++; $display("FAIL rd0_done: lat=%0d required %0d", lat, LAT_NORM); end
      checks++;
      if (weo !== 1'b0) begin errors++; $display("FAIL rd0_we: we=%b required 0", weo); end
      checks++;
      if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rd0_data: data=%h required fffffffe", d); end
   endtask

   task automatic test_ignore_start();
      int lat; int guard; logic seen; logic [31:0] d; logic [4:0] ro;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 200) begin @(negedge clk); guard++; end
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.rd_in = 5'd7; bus.op_a = 32'd3; bus.op_b = 32'd4;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.funct3 = 3'b100; bus.rd_in = 5'd9; bus.op_a = 32'd100; bus.op_b = 32'd5;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = -1; d = '0; ro = '0;
      for (int i = 6; i <= 100; i++) begin
         if (bus.done) begin lat = i; d = bus.data_out; ro = bus.rd; break; end
         @(posedge clk);
         #1;
      end
      $display("op ignore-start first=MUL 3*4 rd=7 -> data=%h rd=%0d lat=%0d", d, ro, lat);
      checks++;
      if (lat !== LAT_NORM) begin errors++; $display("FAIL ign_lat: lat=%0d required %0d", lat, LAT_NORM); end
      checks++;
      if (d !== 32'd12 || ro !== 5'd7) begin
         errors++;
         $display("FAIL ign_result: data=%h rd=%0d required 0000000c/7", d, ro);
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL ign_no_queue: done_seen=%b required 0", seen); end
   endtask

   task automatic test_reset_midop();
      int guard; logic seen; int lat; logic [31:0] d; logic [4:0] ro; logic weo, ba;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 200) begin @(negedge clk); guard++; end
      bus.start = 1'b1; bus.funct3 = 3'b011; bus.rd_in = 5'd4;
      bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      $display("op reset at iteration 10 -> busy=%b done=%b we=%b rd=%0d data=%h",
               bus.busy, bus.done, bus.we, bus.rd, bus.data_out);
      checks++;
      if ({bus.busy, bus.done, bus.we} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_ctrl: busy/done/we=%b required 000", {bus.busy, bus.done, bus.we});
      end
      checks++;
      if (bus.rd !== 5'd0 || bus.data_out !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_data: rd=%0d data=%h required 0/0", bus.rd, bus.data_out);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: activity=%b required 0", seen); end
      do_op(3'b101, 5'd6, 32'd100, 32'd7, lat, d, ro, weo, ba);
      checks++;
      if (d !== 32'd14 || ro !== 5'd6 || weo !== 1'b1 || lat !== LAT_NORM) begin
         errors++;
         $display("FAIL rst_mid_next: data=%h rd=%0d we=%b lat=%0d required 0000000e/6/1/%0d",
                  d, ro, weo, lat, LAT_NORM);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mul_high();
      test_div_rem();
      test_special();
      test_rd_zero();
      test_ignore_start();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
